captura_z: RTL and testbench

// - Downstream consumer of the Parte2 FSM.
// - Samples its 3-bit code Z on every clock where flag I=1 and en=1, then queues the

---
 rtl/captura_z_pkg.sv | 18 +
 rtl/captura_z_fifo_sinc.sv | 82 ++++++++
 rtl/captura_z.sv | 76 +++++++
 tb/tb_captura_z.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/captura_z_pkg.sv
// Shared definitions for captura_z: code width from Parte2 and the FIFO occupancy view.
package captura_z_pkg;

    localparam int unsigned Z_W = 3;

    typedef enum logic [1:0] {
        OCC_VACIO   = 2'd0,
        OCC_PARCIAL = 2'd1,
        OCC_LLENO   = 2'd2
    } occ_st_e;

    function automatic occ_st_e occ_view(input int unsigned occ, input int unsigned depth);
        if (occ == 0)          return OCC_VACIO;
        else if (occ == depth) return OCC_LLENO;
        else                   return OCC_PARCIAL;
    endfunction

endpackage

// File: rtl/captura_z_fifo_sinc.sv
// Synchronous first-word-fall-through FIFO with a registered VACIO/PARCIAL/LLENO view.
//   state       | meaning
//   OCC_VACIO   | occ == 0, dout forced to 0
//   OCC_PARCIAL | 0 < occ < DEPTH
//   OCC_LLENO   | occ == DEPTH, push only lands if a pop frees a slot
module fifo_sinc
    import captura_z_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = Z_W
) (
    input  logic             clk,
    input  logic             r,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             lleno,
    output logic             vacio,
    output logic             acepta
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    occ_st_e          st_q, st_d;
    logic             do_wr, do_rd;

    // A pop on a full FIFO frees the slot the same-edge push takes.
    always_comb begin
        do_rd    = pop & (occ_q != '0);
        do_wr    = push & ((occ_q != OCC_W'(DEPTH)) | do_rd);
        acepta   = do_wr;
        wr_ptr_d = wr_ptr_q + PTR_W'(do_wr);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_rd);
        occ_d    = occ_q + OCC_W'(do_wr) - OCC_W'(do_rd);
        mem_d    = mem_q;
        if (do_wr) begin
            mem_d[wr_ptr_q] = din;
        end
    end

    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            mem_q    <= mem_d;
        end
    end

    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            st_q <= OCC_VACIO;
        end else begin
            st_q <= st_d;
        end
    end

    always_comb begin
        st_d = occ_view(32'(occ_d), DEPTH);
    end

    always_comb begin
        vacio = (st_q == OCC_VACIO);
        lleno = (st_q == OCC_LLENO);
        dout  = vacio ? '0 : mem_q[rd_ptr_q];
    end

endmodule

// File: rtl/captura_z.sv
// Captures Parte2's Z on I&en into a FWFT queue drained over valid/ready;
// keeps a saturating accepted-sample count and a sticky lost-sample flag.
module captura_z
    import captura_z_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             r,
    input  logic [Z_W-1:0]   Z,
    input  logic             I,
    input  logic             en,
    input  logic             clr,
    input  logic             dout_ready,
    output logic [Z_W-1:0]   dout,
    output logic             dout_valid,
    output logic             lleno,
    output logic             vacio,
    output logic [CNT_W-1:0] cuenta,
    output logic             perdido
);

    logic             push, pop, acepta;
    logic [CNT_W-1:0] cuenta_q, cuenta_d;
    logic             perdido_q, perdido_d;

    assign push       = I & en;
    assign pop        = dout_valid & dout_ready;
    assign dout_valid = ~vacio;
    assign cuenta     = cuenta_q;
    assign perdido    = perdido_q;

    fifo_sinc #(
        .DEPTH (DEPTH),
        .WIDTH (Z_W)
    ) u_fifo (
        .clk    (clk),
        .r      (r),
        .push   (push),
        .pop    (pop),
        .din    (Z),
        .dout   (dout),
        .lleno  (lleno),
        .vacio  (vacio),
        .acepta (acepta)
    );

    // clr overrides both the count of a same-edge push and a same-edge drop.
    always_comb begin
        cuenta_d  = cuenta_q;
        perdido_d = perdido_q;
        if (clr) begin
            cuenta_d  = '0;
            perdido_d = 1'b0;
        end else begin
            if (acepta && (cuenta_q != '1)) begin
                cuenta_d = cuenta_q + CNT_W'(1);
            end
            if (push && !acepta) begin
                perdido_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            cuenta_q  <= '0;
            perdido_q <= 1'b0;
        end else begin
            cuenta_q  <= cuenta_d;
            perdido_q <= perdido_d;
        end
    end

endmodule

// File: tb/tb_captura_z.sv
// Bench for captura_z: queue-based reference model checked every cycle on two
// instances (8-bit and 2-bit counters) plus hand-computed directed expectations.
module tb_captura_z;

    logic       clk = 1'b0;
    logic       r = 1'b0;
    logic [2:0] Z = '0;
    logic       I = 1'b0, en = 1'b0, clr = 1'b0, dout_ready = 1'b0;

    logic [2:0] dout, dout2;
    logic       dout_valid, dout_valid2, lleno, lleno2, vacio, vacio2, perdido, perdido2;
    logic [7:0] cuenta;
    logic [1:0] cuenta2;

    int total = 0;
    int bad   = 0;

    logic [2:0] m_q[$];
    int         m_cnt8 = 0;
    int         m_cnt2 = 0;
    bit         m_perd = 1'b0;

    always #5 clk = ~clk;

    captura_z #(.DEPTH(4), .CNT_W(8)) u_dut (
        .clk(clk), .r(r), .Z(Z), .I(I), .en(en), .clr(clr), .dout_ready(dout_ready),
        .dout(dout), .dout_valid(dout_valid), .lleno(lleno), .vacio(vacio),
        .cuenta(cuenta), .perdido(perdido)
    );

    captura_z #(.DEPTH(4), .CNT_W(2)) u_dut2 (
        .clk(clk), .r(r), .Z(Z), .I(I), .en(en), .clr(clr), .dout_ready(dout_ready),
        .dout(dout2), .dout_valid(dout_valid2), .lleno(lleno2), .vacio(vacio2),
        .cuenta(cuenta2), .perdido(perdido2)
    );

    // Reference: a queue of at most 4 samples; pop first so a full queue with ready accepts.
    always @(posedge clk or negedge r) begin
        bit acc;
        acc = 1'b0;
        if (!r) begin
            m_q.delete();
            m_cnt8 = 0;
            m_cnt2 = 0;
            m_perd = 1'b0;
        end else begin
            if (m_q.size() > 0 && dout_ready) void'(m_q.pop_front());
            if (I && en) begin
                if (m_q.size() < 4) begin
                    m_q.push_back(Z);
                    acc = 1'b1;
                end else begin
                    m_perd = 1'b1;
                end
            end
            if (clr) begin
                m_cnt8 = 0;
                m_cnt2 = 0;
                m_perd = 1'b0;
            end else if (acc) begin
                if (m_cnt8 < 255) m_cnt8++;
                if (m_cnt2 < 3)   m_cnt2++;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        int n;
        int head;
        n    = m_q.size();
        head = (n > 0) ? int'(m_q[0]) : 0;
        chk("dout",        int'(dout),        head);
        chk("dout_valid",  int'(dout_valid),  int'(n > 0));
        chk("vacio",       int'(vacio),       int'(n == 0));
        chk("lleno",       int'(lleno),       int'(n == 4));
        chk("cuenta",      int'(cuenta),      m_cnt8);
        chk("perdido",     int'(perdido),     int'(m_perd));
        chk("dout2",       int'(dout2),       head);
        chk("dout_valid2", int'(dout_valid2), int'(n > 0));
        chk("lleno2",      int'(lleno2),      int'(n == 4));
        chk("vacio2",      int'(vacio2),      int'(n == 0));
        chk("cuenta2",     int'(cuenta2),     m_cnt2);
        chk("perdido2",    int'(perdido2),    int'(m_perd));
    endtask

    task automatic tick();
        @(negedge clk);
        check_model();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] exp4 [4];

        repeat (2) @(negedge clk);
        r = 1'b1;
        tick();
        chk("rst_vacio",   int'(vacio), 1);
        chk("rst_valid",   int'(dout_valid), 0);
        chk("rst_dout",    int'(dout), 0);
        chk("rst_lleno",   int'(lleno), 0);
        chk("rst_cuenta",  int'(cuenta), 0);
        chk("rst_perdido", int'(perdido), 0);

        // single capture, held until ready
        en = 1'b1; I = 1'b1; Z = 3'b101; dout_ready = 1'b0;
        tick();
        I = 1'b0;
        chk("t2_dout",   int'(dout), 5);
        chk("t2_valid",  int'(dout_valid), 1);
        chk("t2_cuenta", int'(cuenta), 1);
        Z = 3'b010;
        repeat (3) tick();
        chk("t2_hold", int'(dout), 5);
        dout_ready = 1'b1;
        tick();
        chk("t2_drained", int'(vacio), 1);
        dout_ready = 1'b0;

        // fill and drop
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            Z = 3'(i); I = 1'b1;
            tick();
            if (i == 4) begin
                chk("t3_lleno",   int'(lleno), 1);
                chk("t3_perd_pre", int'(perdido), 0);
            end
        end
        I = 1'b0;
        chk("t3_perdido", int'(perdido), 1);
        chk("t3_cuenta",  int'(cuenta), 4);
        chk("t3_cuenta2", int'(cuenta2), 3);
        dout_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("t3_drain", int'(dout), i);
            tick();
        end
        chk("t3_vacio", int'(vacio), 1);
        dout_ready = 1'b0;

        // full plus simultaneous push/pop
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            Z = 3'(i); I = 1'b1;
            tick();
        end
        chk("t4_full", int'(lleno), 1);
        dout_ready = 1'b1; I = 1'b1; Z = 3'd6;
        tick();
        I = 1'b0; dout_ready = 1'b0;
        chk("t4_head",    int'(dout), 2);
        chk("t4_lleno",   int'(lleno), 1);
        chk("t4_perdido", int'(perdido), 0);
        chk("t4_cuenta",  int'(cuenta), 5);
        exp4[0] = 3'd2; exp4[1] = 3'd3; exp4[2] = 3'd4; exp4[3] = 3'd6;
        dout_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t4_drain", int'(dout), int'(exp4[i]));
            tick();
        end
        chk("t4_vacio", int'(vacio), 1);
        dout_ready = 1'b0;

        // saturation and clr with a same-edge push
        clr = 1'b1;
        tick();
        clr = 1'b0;
        dout_ready = 1'b1; I = 1'b1;
        for (int i = 0; i < 5; i++) begin
            Z = 3'(i);
            tick();
        end
        I = 1'b0;
        chk("t5_sat2",    int'(cuenta2), 3);
        chk("t5_cuenta8", int'(cuenta), 5);
        tick();
        chk("t5_vacio", int'(vacio), 1);
        dout_ready = 1'b0; clr = 1'b1; I = 1'b1; Z = 3'd7;
        tick();
        clr = 1'b0; I = 1'b0;
        chk("t5_clr_cnt",   int'(cuenta), 0);
        chk("t5_clr_cnt2",  int'(cuenta2), 0);
        chk("t5_clr_dout",  int'(dout), 7);
        chk("t5_clr_valid", int'(dout_valid), 1);
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;

        // asynchronous reset with entries queued
        for (int i = 1; i <= 3; i++) begin
            Z = 3'(i); I = 1'b1;
            tick();
        end
        I = 1'b0;
        chk("t1_pre_cuenta", int'(cuenta), 3);
        #2 r = 1'b0;
        #1;
        chk("t1_valid",   int'(dout_valid), 0);
        chk("t1_vacio",   int'(vacio), 1);
        chk("t1_dout",    int'(dout), 0);
        chk("t1_cuenta",  int'(cuenta), 0);
        chk("t1_perdido", int'(perdido), 0);
        @(negedge clk);
        r = 1'b1;
        tick();

        // gating: en=0 never captures
        en = 1'b0;
        for (int i = 0; i < 30; i++) begin
            Z = 3'($urandom_range(7));
            I = 1'($urandom_range(1));
            dout_ready = 1'($urandom_range(1));
            tick();
            chk("t6_gate_vacio",  int'(vacio), 1);
            chk("t6_gate_cuenta", int'(cuenta), 0);
        end

        // random traffic with capture enabled
        en = 1'b1;
        for (int i = 0; i < 30; i++) begin
            Z = 3'($urandom_range(7));
            I = 1'($urandom_range(1));
            dout_ready = 1'($urandom_range(1));
            clr = ($urandom_range(15) == 0);
            tick();
        end
        en = 1'b0; I = 1'b0; clr = 1'b0; dout_ready = 1'b1;
        repeat (6) tick();
        chk("t6_final_vacio", int'(vacio), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
